// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter: one-hot grant held until packet end, retry, abandon or hold timeout.
// Optional per-master retry backoff masking is enabled by defining SB_RETRY_BACKOFF_EN.
module snoop_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MAX_HOLD       = 64,
  parameter int BACKOFF_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         req_i,
  input  logic                           bus_valid_i,
  input  logic                           bus_end_i,
  input  logic                           retry_i,
  output logic [NUM_MASTERS-1:0]         gnt_o,
  output logic [$clog2(NUM_MASTERS)-1:0] owner_o,
  output logic                           busy_o,
  output logic                           timeout_o,
  output logic                           retry_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_HOLD < 4 || BACKOFF_CYCLES < 1) begin : g_param_check
    $error("snoop_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANTED, TURNAROUND} state_t;

  state_t                   state;
  logic [IW-1:0]            rr_ptr;
  logic [HW-1:0]            hold_cnt;
  logic                     seen_valid;
  logic [NUM_MASTERS-1:0]   eligible;
  logic                     found;
  logic [IW-1:0]            pick;
  logic                     abandon;
  logic                     hold_expired;
  logic                     grant_exit;
  logic [IW-1:0]            next_ptr;

`ifdef SB_RETRY_BACKOFF_EN
  localparam int BW = $clog2(BACKOFF_CYCLES + 1);
  logic [BW-1:0] backoff [NUM_MASTERS];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      eligible[i] = req_i[i] && (backoff[i] == '0);
    end
  end

  // A retried owner sits out arbitration until its counter drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MASTERS; i++) backoff[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (state == GRANTED && retry_i && owner_o == IW'(i)) begin
          backoff[i] <= BW'(BACKOFF_CYCLES);
        end else if (backoff[i] != '0) begin
          backoff[i] <= backoff[i] - BW'(1);
        end
      end
    end
  end
`else
  assign eligible = req_i;
`endif

  // First eligible requester searching upward from the rr pointer, wrapping.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_v;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_v = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      idx_v = IW'(idx);
      if (!found && eligible[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  end

  assign abandon      = !req_i[owner_o] && !seen_valid && !bus_valid_i;
  assign hold_expired = (hold_cnt == HOLD_LAST);
  assign grant_exit   = retry_i || bus_end_i || abandon || hold_expired;
  assign next_ptr     = (owner_o == IW'(NUM_MASTERS - 1)) ? '0 : owner_o + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_o      <= '0;
      owner_o    <= '0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
      retry_o    <= 1'b0;
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      seen_valid <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      retry_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state      <= GRANTED;
            gnt_o      <= ONE_HOT0 << pick;
            owner_o    <= pick;
            busy_o     <= 1'b1;
            hold_cnt   <= '0;
            seen_valid <= 1'b0;
          end
        end
        GRANTED: begin
          if (!hold_expired) hold_cnt <= hold_cnt + HW'(1);
          if (bus_valid_i) seen_valid <= 1'b1;
          if (grant_exit) begin
            state     <= TURNAROUND;
            gnt_o     <= '0;
            busy_o    <= 1'b0;
            rr_ptr    <= next_ptr;
            retry_o   <= retry_i;
            // A timeout pulse only when nothing of higher priority ended the grant.
            timeout_o <= hold_expired && !retry_i && !bus_end_i && !abandon;
          end
        end
        TURNAROUND: state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed testbench for snoop_bus_arbiter (4 masters, MAX_HOLD 64, BACKOFF_CYCLES 8).
module tb_snoop_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       bus_valid;
  logic       bus_end;
  logic       retry;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;
  logic       retry_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.NUM_MASTERS(4), .MAX_HOLD(64), .BACKOFF_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_i(req), .bus_valid_i(bus_valid), .bus_end_i(bus_end),
    .retry_i(retry), .gnt_o(gnt), .owner_o(owner), .busy_o(busy),
    .timeout_o(timeout), .retry_o(retry_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; bus_valid = 1'b0; bus_end = 1'b0; retry = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int bound, output int n);
    n = 0;
    while (gnt == 4'b0000 && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic release_bus();
    req = '0; bus_valid = 1'b1; bus_end = 1'b1;
    step();
    bus_valid = 1'b0; bus_end = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL reset_owner got %0d want 0", owner); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (timeout !== 1'b0 || retry_out !== 1'b0) begin
      fails++; $display("FAIL reset_pulses got timeout=%b retry=%b want 0 0", timeout, retry_out);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    req = 4'b0101;
    step();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL basic_gnt0 got %b want 0001", gnt); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL basic_owner0 got %0d want 0", owner); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
    bus_valid = 1'b1; bus_end = 1'b1;
    step();
    bus_valid = 1'b0; bus_end = 1'b0;
    tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_turnaround got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL basic_idle got %b want 0000", gnt); end
    step();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL basic_gnt2 got %b want 0100", gnt); end
    tests++; if (owner !== 2'd2) begin fails++; $display("FAIL basic_owner2 got %0d want 2", owner); end
    release_bus();
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] exp;
    apply_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(10, n);
      exp = 4'b0001 << (g % 4);
      tests++; if (gnt !== exp) begin fails++; $display("FAIL rr_order grant %0d got %b want %b", g, gnt, exp); end
      if (g > 0) begin
        tests++; if (n !== 2) begin fails++; $display("FAIL rr_gap grant %0d got %0d idle cycles want 2", g, n); end
      end
      bus_valid = 1'b1;
      step(); step();
      bus_end = 1'b1;
      step();
      bus_end = 1'b0; bus_valid = 1'b0;
    end
    req = '0;
    step(); step(); step();
  endtask

  task automatic test_timeout();
    int cnt;
    int early;
    int n;
    apply_reset();
    req = 4'b0010;
    step();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL to_gnt1 got %b want 0010", gnt); end
    req = 4'b0110; bus_valid = 1'b1;
    cnt = 1; early = 0;
    while (cnt < 200) begin
      step();
      bus_valid = 1'b0;
      if (gnt == 4'b0000) break;
      cnt++;
      if (timeout) early++;
    end
    tests++; if (cnt !== 64) begin fails++; $display("FAIL to_hold_cycles got %0d want 64", cnt); end
    tests++; if (early !== 0) begin fails++; $display("FAIL to_early_pulse got %0d want 0", early); end
    tests++; if (timeout !== 1'b1 || retry_out !== 1'b0) begin
      fails++; $display("FAIL to_pulse got timeout=%b retry=%b want 1 0", timeout, retry_out);
    end
    step();
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL to_pulse_width got %b want 0", timeout); end
    wait_grant(10, n);
    tests++; if (gnt !== 4'b0100 || owner !== 2'd2) begin
      fails++; $display("FAIL to_next_gnt got gnt=%b owner=%0d want 0100 2", gnt, owner);
    end
    release_bus();
  endtask

  task automatic test_retry();
    apply_reset();
    req = 4'b0100;
    step();
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rt_gnt2 got %b want 0100", gnt); end
    req = 4'b1100; retry = 1'b1; bus_end = 1'b1; bus_valid = 1'b1;
    step();
    retry = 1'b0; bus_end = 1'b0; bus_valid = 1'b0;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rt_release got %b want 0000", gnt); end
    tests++; if (retry_out !== 1'b1 || timeout !== 1'b0) begin
      fails++; $display("FAIL rt_pulse got retry=%b timeout=%b want 1 0", retry_out, timeout);
    end
    step();
    tests++; if (retry_out !== 1'b0) begin fails++; $display("FAIL rt_pulse_width got %b want 0", retry_out); end
    step();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL rt_rr_ptr got %b want 1000", gnt); end
    release_bus();
  endtask

  task automatic test_retry_regrant();
    int n;
    int exp_n;
`ifdef SB_RETRY_BACKOFF_EN
    exp_n = 9;
`else
    exp_n = 2;
`endif
    apply_reset();
    req = 4'b0100;
    step();
    retry = 1'b1;
    step();
    retry = 1'b0;
    tests++; if (retry_out !== 1'b1) begin fails++; $display("FAIL rr2_pulse got %b want 1", retry_out); end
    wait_grant(40, n);
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rr2_regrant got %b want 0100", gnt); end
    tests++; if (n !== exp_n) begin fails++; $display("FAIL rr2_latency got %0d want %0d", n, exp_n); end
    release_bus();
  endtask

  task automatic test_abandon();
    apply_reset();
    req = 4'b1000;
    step();
    tests++; if (gnt !== 4'b1000 || owner !== 2'd3) begin
      fails++; $display("FAIL ab_gnt3 got gnt=%b owner=%0d want 1000 3", gnt, owner);
    end
    req = 4'b0000;
    step();
    tests++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      fails++; $display("FAIL ab_release got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    tests++; if (timeout !== 1'b0 || retry_out !== 1'b0) begin
      fails++; $display("FAIL ab_pulses got timeout=%b retry=%b want 0 0", timeout, retry_out);
    end
    step(); step();
    req = 4'b1000;
    step();
    bus_valid = 1'b1;
    step();
    bus_valid = 1'b0; req = 4'b0000;
    step();
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL ab_started_hold got %b want 1000", gnt); end
    bus_end = 1'b1;
    step();
    bus_end = 1'b0;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL ab_end_release got %b want 0000", gnt); end
    step(); step();
    retry = 1'b1; bus_end = 1'b1;
    step();
    retry = 1'b0; bus_end = 1'b0;
    tests++; if (retry_out !== 1'b0 || gnt !== 4'b0000) begin
      fails++; $display("FAIL ab_idle_ignore got retry=%b gnt=%b want 0 0000", retry_out, gnt);
    end
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0010;
    step();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL rm_gnt1 got %b want 0010", gnt); end
    rst = 1'b1; req = 4'b0111;
    step();
    tests++; if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      fails++; $display("FAIL rm_outputs got gnt=%b busy=%b owner=%0d want 0000 0 0", gnt, busy, owner);
    end
    tests++; if (timeout !== 1'b0 || retry_out !== 1'b0) begin
      fails++; $display("FAIL rm_pulses got timeout=%b retry=%b want 0 0", timeout, retry_out);
    end
    rst = 1'b0;
    step();
    tests++; if (gnt !== 4'b0001 || owner !== 2'd0) begin
      fails++; $display("FAIL rm_restart got gnt=%b owner=%0d want 0001 0", gnt, owner);
    end
    release_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired gnt=%b", gnt);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_retry();
    test_retry_regrant();
    test_abandon();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
